uart_tx_scheduler: RTL

Shares the single UART transmit line between two byte-stream requesters and serialises the granted bytes as 8N1 frames timed by the 16x-oversampled baud tick (16 × 19200 Hz from the 50 MHz board clock). It sits between the servo/telemetry packet producers and the TX pin. It owns arbitration, packet locking and bit sequencing. The baud rate itself comes from the upstream tick generator.

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_tx_scheduler_rr_arbiter2.sv | 41 ++++
 rtl/uart_tx_scheduler.sv | 107 ++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared constants and FSM encoding for the UART transmit scheduler.
package uart_pkg;

  localparam int OVERSAMPLE  = 16;
  localparam int DATA_BITS   = 8;
  localparam int BAUD_RATE   = 19200;
  localparam int CLK_FREQ_HZ = 50_000_000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

endpackage

// File: rtl/uart_tx_scheduler_rr_arbiter2.sv
// Two-way round-robin arbiter with packet lock; ready is combinational from
// the pointer/lock registers and the valids while the FSM can load.
module rr_arbiter2 (
  input  logic       clk50MHz,
  input  logic       rst,
  input  logic       load,
  input  logic [1:0] valid,
  input  logic [1:0] last,
  output logic [1:0] ready,
  output logic       winner
);

  logic       rrPtr;
  logic       locked;
  logic       lockId;
  logic [1:0] elig;

  always_comb begin
    elig = valid;
    if (locked) elig = valid & (lockId ? 2'b10 : 2'b01);
    winner = rrPtr;
    if (elig == 2'b01)      winner = 1'b0;
    else if (elig == 2'b10) winner = 1'b1;
    ready = 2'b00;
    if (load && (elig != 2'b00)) ready = winner ? 2'b10 : 2'b01;
  end

  // A byte without last keeps the line reserved for the rest of its packet.
  always_ff @(posedge clk50MHz or posedge rst) begin
    if (rst) begin
      rrPtr  <= 1'b0;
      locked <= 1'b0;
      lockId <= 1'b0;
    end else if (|ready) begin
      rrPtr  <= ~winner;
      locked <= ~last[winner];
      lockId <= winner;
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Arbitrates two byte streams onto one 8N1 TX line, bit timing from the
// 16x baud tick. txd is registered so the pin never glitches.
module uart_tx_scheduler #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8
) (
  input  logic                 clk50MHz,
  input  logic                 rst,
  input  logic                 baudTick,
  input  logic                 req0Valid,
  input  logic [DATA_BITS-1:0] req0Data,
  input  logic                 req0Last,
  output logic                 req0Ready,
  input  logic                 req1Valid,
  input  logic [DATA_BITS-1:0] req1Data,
  input  logic                 req1Last,
  output logic                 req1Ready,
  output logic                 txd,
  output logic                 busy,
  output logic                 grantId
);

  import uart_pkg::*;

  localparam int TICK_W = $clog2(OVERSAMPLE);
  localparam int BIT_W  = $clog2(DATA_BITS);

  tx_state_t            state, stateNext;
  logic [TICK_W-1:0]    tickCnt, tickNext;
  logic [BIT_W-1:0]     bitCnt, bitNext;
  logic [DATA_BITS-1:0] shift, shiftNext;
  logic                 grantNext, txdNext, bitEnd, winner, canLoad;
  logic [1:0]           ready;

  assign canLoad   = (state == IDLE) && !rst;
  assign busy      = (state != IDLE);
  assign req0Ready = ready[0];
  assign req1Ready = ready[1];

  rr_arbiter2 u_arb (
    .clk50MHz (clk50MHz),
    .rst      (rst),
    .load     (canLoad),
    .valid    ({req1Valid, req0Valid}),
    .last     ({req1Last, req0Last}),
    .ready    (ready),
    .winner   (winner)
  );

  always_comb begin
    stateNext = state;
    tickNext  = tickCnt;
    bitNext   = bitCnt;
    shiftNext = shift;
    grantNext = grantId;
    bitEnd    = baudTick && (tickCnt == TICK_W'(OVERSAMPLE - 1));
    if ((state != IDLE) && baudTick) tickNext = bitEnd ? '0 : tickCnt + 1'b1;
    unique case (state)
      IDLE: begin
        if (|ready) begin
          stateNext = START;
          tickNext  = '0;
          bitNext   = '0;
          shiftNext = ready[1] ? req1Data : req0Data;
          grantNext = winner;
        end
      end
      START: if (bitEnd) stateNext = DATA;
      DATA: begin
        if (bitEnd) begin
          shiftNext = shift >> 1;
          if (bitCnt == BIT_W'(DATA_BITS - 1)) begin
            stateNext = STOP;
            bitNext   = '0;
          end else begin
            bitNext = bitCnt + 1'b1;
          end
        end
      end
      STOP: if (bitEnd) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
    // txd follows the state being entered so it changes on the same edge.
    txdNext = 1'b1;
    if (stateNext == START)     txdNext = 1'b0;
    else if (stateNext == DATA) txdNext = shiftNext[0];
  end

  always_ff @(posedge clk50MHz or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      tickCnt <= '0;
      bitCnt  <= '0;
      shift   <= '0;
      grantId <= 1'b0;
      txd     <= 1'b1;
    end else begin
      state   <= stateNext;
      tickCnt <= tickNext;
      bitCnt  <= bitNext;
      shift   <= shiftNext;
      grantId <= grantNext;
      txd     <= txdNext;
    end
  end

endmodule
